// File: rtl/fb_scan_arbiter.sv
// Purpose: single-port frame-buffer scheduler between display scan-out and one pixel writer,
//          with frame-aligned double-buffer swapping (enabled by defining FB_DOUBLE_BUF_EN).
// Latency: fetch slot to pix_valid is MEM_LAT+2 cycles; accepted write reaches mem_* one cycle later.
// Backpressure: wr_ready drops combinationally on every display fetch slot; display is never stalled.
//
// Ports:
//   pixel_clk, rst_n            clock, asynchronous active-low reset
//   h_count, v_count, new_frame timing generator position and end-of-frame pulse
//   wr_valid/wr_addr/wr_data    writer request into the back buffer, wr_ready = accepted this cycle
//   swap_req/swap_ack           writer finished back buffer / swap committed (single-cycle pulses)
//   mem_en/mem_we/mem_addr/     registered single-port memory interface, mem_addr = {buffer_sel, offset}
//   mem_wdata/mem_rdata
//   pix_data/pix_valid          fetched display pixel (held) and its one-cycle update strobe
//
// Without FB_DOUBLE_BUF_EN the design is single-buffered: buffer select is always 0 and
// swap_ack simply echoes swap_req one cycle later.

module fb_scan_arbiter #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int SCALE           = 4,
    parameter int PIX_W           = 16,
    parameter int MEM_LAT         = 2,
    parameter int H_W             = 11,
    parameter int V_W             = 10,
    localparam int FB_W           = ACTIVE_H_PIXELS / SCALE,
    localparam int FB_H           = ACTIVE_LINES / SCALE,
    localparam int AW             = $clog2(FB_W * FB_H)
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    input  logic [H_W-1:0]   h_count,
    input  logic [V_W-1:0]   v_count,
    input  logic             new_frame,
    input  logic             wr_valid,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             swap_req,
    output logic             swap_ack,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW:0]      mem_addr,
    output logic [PIX_W-1:0] mem_wdata,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid
);

    localparam int CW = (FB_W > 1) ? $clog2(FB_W) : 1;

    localparam logic [H_W-1:0] H_ACT   = H_W'(ACTIVE_H_PIXELS);
    localparam logic [H_W-1:0] H_LAST  = H_W'(ACTIVE_H_PIXELS - 1);
    localparam logic [H_W-1:0] H_MASK  = H_W'(SCALE - 1);
    localparam logic [V_W-1:0] V_ACT   = V_W'(ACTIVE_LINES);
    localparam logic [V_W-1:0] V_LAST  = V_W'(ACTIVE_LINES - 1);
    localparam logic [V_W-1:0] V_MASK  = V_W'(SCALE - 1);
    localparam logic [AW-1:0]  FB_W_A  = AW'(FB_W);
    localparam logic [CW-1:0]  COL_END = CW'(FB_W - 1);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic          fetch_slot;
    logic          wr_acc;
    logic          front_sel;
    logic          wr_sel;
    logic [CW-1:0] col_eff;
    logic [AW-1:0] rd_off;

    logic [CW-1:0]      col_q, col_d;
    logic [AW-1:0]      line_base_q, line_base_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [AW:0]        mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEM_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [PIX_W-1:0]   pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic               swap_ack_q, swap_ack_d;

    assign fetch_slot = (h_count < H_ACT) && (v_count < V_ACT) && ((h_count & H_MASK) == '0);
    assign wr_ready   = !fetch_slot;
    assign wr_acc     = wr_valid && !fetch_slot;

    // The column counter is cleared by the edge that ends h_count==0, so the first fetch of a
    // line must already see column 0 even though col_q still holds last line's value.
    assign col_eff = (h_count == '0) ? '0 : col_q;
    assign rd_off  = line_base_q + AW'(col_eff);

    always_comb begin
        col_d = col_eff;
        if (fetch_slot) begin
            col_d = (col_eff == COL_END) ? '0 : col_eff + CW'(1);
        end
    end

    // The step after the last active line is skipped so line_base stays within the last
    // buffer row; new_frame brings it back to 0 before the next frame anyway.
    always_comb begin
        line_base_d = line_base_q;
        if (new_frame) begin
            line_base_d = '0;
        end else if ((h_count == H_LAST) && (v_count < V_LAST) && ((v_count & V_MASK) == V_MASK)) begin
            line_base_d = line_base_q + FB_W_A;
        end
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (fetch_slot) begin
            mem_en_d   = 1'b1;
            mem_addr_d = {front_sel, rd_off};
        end else if (wr_acc) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {wr_sel, wr_addr};
            mem_wdata_d = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read return: one bit per issued read walks MEM_LAT stages; when it leaves the last
    // stage the memory is presenting that read's data.
    // ------------------------------------------------------------------
    always_comb begin
        rd_pipe_d   = MEM_LAT'({rd_pipe_q, (mem_en_q & ~mem_we_q)});
        pix_valid_d = rd_pipe_q[MEM_LAT-1];
        pix_data_d  = rd_pipe_q[MEM_LAT-1] ? mem_rdata : pix_data_q;
    end

    // ------------------------------------------------------------------
    // Buffer swap
    // ------------------------------------------------------------------
`ifdef FB_DOUBLE_BUF_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0] state_q, state_d;
    logic       front_sel_q, front_sel_d;

    // front_sel only moves on the new_frame edge, so a displayed frame never mixes buffers.
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_ack_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (swap_req && new_frame) begin
                front_sel_d = ~front_sel_q;
                swap_ack_d  = 1'b1;
            end else if (swap_req) begin
                state_d = ST_PEND;
            end
        end else begin
            // Further swap_req pulses here are ignored: one request, one toggle.
            if (new_frame) begin
                front_sel_d = ~front_sel_q;
                swap_ack_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
        end
    end

    assign front_sel = front_sel_q;
    assign wr_sel    = ~front_sel_q;
`else
    assign front_sel  = 1'b0;
    assign wr_sel     = 1'b0;
    assign swap_ack_d = swap_req;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            line_base_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pipe_q   <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            line_base_q <= line_base_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            swap_ack_q  <= swap_ack_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign swap_ack  = swap_ack_q;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Purpose: scoreboard bench for fb_scan_arbiter at default parameters (MEM_LAT=2).
// Latency: expected memory ops are due one cycle after issue, pixels four cycles after the fetch slot.
// Backpressure: wr_ready is compared inline against the fetch-slot rule every driven cycle.

module tb_fb_scan_arbiter;

`ifdef FB_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        pixel_clk;
    logic        rst_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        new_frame;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        swap_req;
    logic        swap_ack;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] pix_data;
    logic        pix_valid;

    fb_scan_arbiter #(.MEM_LAT(2)) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .h_count   (h_count),
        .v_count   (v_count),
        .new_frame (new_frame),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc++;

    // Memory model: data is a fixed function of the address, returned two cycles after the read.
    function automatic logic [15:0] mem_hash(input logic [16:0] a);
        return {a[7:0], a[15:8]} ^ {a[16], 15'd0} ^ 16'h5A3C;
    endfunction

    logic [15:0] rp1, rp2;
    always @(posedge pixel_clk) begin
        rp1 <= mem_hash(mem_addr);
        rp2 <= rp1;
    end
    assign mem_rdata = rp2;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [15:0] wdata;
        int          due;
    } mem_exp_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } pix_exp_t;

    mem_exp_t exp_mem[$];
    pix_exp_t exp_pix[$];
    int       exp_ack[$];

    int checks = 0;
    int errors = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_pix = 0;
    bit exp_front = 1'b0;
    bit exp_pend  = 1'b0;

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard whenever the DUT presents an output
    // ------------------------------------------------------------------
    always @(negedge pixel_clk) begin
        if (rst_n) begin
            if (mem_en) begin
                if (mem_we) n_wr++;
                else        n_rd++;
            end
            if (pix_valid) n_pix++;

            if (exp_mem.size() > 0 && exp_mem[0].due == cyc) begin
                mem_exp_t e;
                e = exp_mem.pop_front();
                checks++;
                if (!mem_en || mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL mem_op cyc=%0d actual en=%b we=%b addr=%h wdata=%h required en=1 we=%b addr=%h wdata=%h",
                             cyc, mem_en, mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                end
            end else begin
                checks++;
                if (mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_idle cyc=%0d actual en=%b we=%b addr=%h required en=0", cyc, mem_en, mem_we, mem_addr);
                end
            end

            if (exp_pix.size() > 0 && exp_pix[0].due == cyc) begin
                pix_exp_t p;
                p = exp_pix.pop_front();
                checks++;
                if (pix_valid !== 1'b1 || pix_data !== p.data) begin
                    errors++;
                    $display("FAIL pix cyc=%0d actual valid=%b data=%h required valid=1 data=%h", cyc, pix_valid, pix_data, p.data);
                end
            end else if (pix_valid) begin
                checks++;
                errors++;
                $display("FAIL pix_unexpected cyc=%0d actual valid=1 data=%h required valid=0", cyc, pix_data);
            end

            if (exp_ack.size() > 0 && exp_ack[0] == cyc) begin
                void'(exp_ack.pop_front());
                checks++;
                if (swap_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL swap_ack cyc=%0d actual %b required 1", cyc, swap_ack);
                end
            end else if (swap_ack) begin
                checks++;
                errors++;
                $display("FAIL swap_ack_unexpected cyc=%0d actual 1 required 0", cyc);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: drive one cycle and push what it must produce
    // ------------------------------------------------------------------
    task automatic step(input int h, input int v, input bit nf, input bit wv,
                        input int wa, input int wd, input bit sr);
        bit       fetch;
        int       off;
        mem_exp_t e;
        pix_exp_t p;
        @(posedge pixel_clk);
        #1;
        h_count   = 11'(h);
        v_count   = 10'(v);
        new_frame = nf;
        wr_valid  = wv;
        wr_addr   = 16'(wa);
        wr_data   = 16'(wd);
        swap_req  = sr;
        fetch = (h < 1280) && (v < 720) && (h % 4 == 0);
        #1;
        checks++;
        if (wr_ready !== !fetch) begin
            errors++;
            $display("FAIL wr_ready h=%0d v=%0d actual %b required %b", h, v, wr_ready, !fetch);
        end
        if (fetch) begin
            off     = (v / 4) * 320 + h / 4;
            e.we    = 1'b0;
            e.addr  = {exp_front, 16'(off)};
            e.wdata = '0;
            e.due   = cyc + 1;
            exp_mem.push_back(e);
            p.data = mem_hash(e.addr);
            p.due  = cyc + 4;
            exp_pix.push_back(p);
        end else if (wv) begin
            e.we    = 1'b1;
            e.addr  = {(DBL ? ~exp_front : 1'b0), 16'(wa)};
            e.wdata = 16'(wd);
            e.due   = cyc + 1;
            exp_mem.push_back(e);
        end
        if (DBL) begin
            if (!exp_pend) begin
                if (sr && nf) begin
                    exp_ack.push_back(cyc + 1);
                    exp_front = ~exp_front;
                end else if (sr) begin
                    exp_pend = 1'b1;
                end
            end else if (nf) begin
                exp_ack.push_back(cyc + 1);
                exp_front = ~exp_front;
                exp_pend  = 1'b0;
            end
        end else if (sr) begin
            exp_ack.push_back(cyc + 1);
        end
    endtask

    task automatic idle_inputs();
        h_count   = 11'd1300;
        v_count   = 10'd0;
        new_frame = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        swap_req  = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            pix_data !== '0 || pix_valid !== 1'b0 || swap_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s actual en=%b we=%b addr=%h wdata=%h pix=%h pv=%b ack=%b required all 0",
                     name, mem_en, mem_we, mem_addr, mem_wdata, pix_data, pix_valid, swap_ack);
        end
    endtask

    task automatic chk_count(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge pixel_clk);
        #2;
        chk_zero("reset_state");
        @(posedge pixel_clk);
        #1 rst_n = 1'b1;

        // Reset mid-frame with a read still in flight
        step(0, 0, 0, 1, 16'h0011, 16'h1111, 0);
        step(1, 0, 0, 1, 16'h0022, 16'h2222, 0);
        step(2, 0, 0, 1, 16'h0033, 16'h3333, 0);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        exp_mem.delete();
        exp_pix.delete();
        exp_ack.delete();
        exp_front = 1'b0;
        exp_pend  = 1'b0;
        #1;
        chk_zero("reset_midframe");
        @(posedge pixel_clk);
        #1 rst_n = 1'b1;
        n_pix = 0;
        for (int h = 1; h < 4; h++) step(h, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1300, 0, 0, 0, 0, 0, 0);
        @(negedge pixel_clk);
        #1 chk_count("no_pix_after_reset", n_pix, 0);

        // One active line with the writer always requesting
        n_rd = 0;
        n_wr = 0;
        for (int h = 0; h < 1280; h++) step(h, 0, 0, 1, h * 5 + 7, h * 3 + 1, 0);
        step(1300, 0, 0, 0, 0, 0, 0);
        @(negedge pixel_clk);
        #1;
        chk_count("line_reads", n_rd, 320);
        chk_count("line_writes", n_wr, 960);

        // Lines 1..4: offsets repeat for 1..3, move to 320.. on line 4
        for (int v = 1; v < 5; v++)
            for (int h = 0; h < 1280; h++) step(h, v, 0, (h % 3 == 0), h + v * 1000, h ^ (v << 8), 0);

        // Advance line_base through the rest of the frame; two swap requests on the way
        for (int v = 5; v < 719; v++) begin
            if (v == 300)
                for (int h = 0; h < 12; h++) step(h, v, 0, 1, 16'hF000 + h, 16'hA500 + h, 0);
            step(1279, v, 0, (v % 50 == 0), v, v * 2 + 1, (v == 100) || (v == 200));
        end
        for (int h = 0; h < 16; h++) step(h, 719, 0, 1, 16'hE000 + h, 16'h7700 + h, 0);
        step(1279, 719, 0, 0, 0, 0, 0);

        // Vertical blanking: writer owns every cycle, then end of frame
        step(1300, 719, 0, 0, 0, 0, 0);
        n_rd = 0;
        for (int v = 720; v < 750; v++) begin
            step(0, v, 0, 1, v, v + 3, 0);
            step(4, v, 0, 1, v + 1, v + 5, 0);
            step(1279, v, 0, 1, v + 2, v + 9, 0);
        end
        step(1649, 749, 1, 0, 0, 0, 0);
        step(1300, 749, 0, 0, 0, 0, 0);
        @(negedge pixel_clk);
        #1 chk_count("blank_reads", n_rd, 0);

        // New frame: offsets from 0, buffer roles as committed
        for (int h = 0; h < 16; h++) step(h, 0, 0, 1, 16'h1230 + h, 16'hC0DE ^ h, 0);

        // swap_req together with new_frame commits at once
        step(1400, 0, 1, 0, 0, 0, 1);
        for (int h = 0; h < 8; h++) step(h, 0, 0, 1, 16'h4560 + h, 16'hBEE0 + h, 0);

        // Lone swap_req
        step(1400, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(1400, 0, 0, 0, 0, 0, 0);

        @(negedge pixel_clk);
        #1;
        chk_count("drain_mem", exp_mem.size(), 0);
        chk_count("drain_pix", exp_pix.size(), 0);
        chk_count("drain_ack", exp_ack.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
